shift_seq_ctrl: RTL and testbench

//  Controller that sequences an external N-bit universal shift register as a full-duplex serial (SPI-mode-0-like) master.
//  Per accepted request it runs three steps:
//   - parallel-load tx_data, then shift right N times, one bit per DIV-cycle bit period;
//   - drive q[0] onto sdo; sample sdi into the register MSB;
//   - present the received word from the register's q.

---
 rtl/shift_seq_pkg.sv | 16 +
 rtl/shift_seq_timer.sv | 37 +++
 rtl/shift_seq_ctrl.sv | 110 +++++++++++
 tb/tb_shift_seq_ctrl.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_seq_pkg.sv
// Shared types and register mode encodings for the serial shift-register sequencer.
// Mode bits are {l, r} as seen on the universal shift register's mode pins.
package shift_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b10;
  localparam logic [1:0] MODE_SHL  = 2'b01;
  localparam logic [1:0] MODE_LOAD = 2'b11;

endpackage

// File: rtl/shift_seq_timer.sv
// Bit-period divider: counts 0..DIV-1 while enabled and derives the sample,
// shift and serial-clock strobes for one bit period.
module shift_seq_timer #(
  parameter int DIV = 4,
  localparam int W  = (DIV > 1) ? $clog2(DIV) : 1
) (
  input  logic c,
  input  logic rst,
  input  logic i_start,
  input  logic i_en,
  output logic o_sample,
  output logic o_shift,
  output logic o_sclk
);

  localparam logic [W-1:0] C_SAMPLE = W'(DIV / 2 - 1);
  localparam logic [W-1:0] C_HALF   = W'(DIV / 2);
  localparam logic [W-1:0] C_LAST   = W'(DIV - 1);

  logic [W-1:0] r_div_cnt;

  always_ff @(posedge c or posedge rst) begin
    if (rst) begin
      r_div_cnt <= '0;
    end else if (i_start) begin
      r_div_cnt <= '0;
    end else if (i_en) begin
      r_div_cnt <= (r_div_cnt == C_LAST) ? '0 : r_div_cnt + 1'b1;
    end
  end

  // sdi is captured on the edge where sclk rises; the register shifts on the edge where it falls.
  assign o_sample = i_en && (r_div_cnt == C_SAMPLE);
  assign o_shift  = i_en && (r_div_cnt == C_LAST);
  assign o_sclk   = i_en && (r_div_cnt >= C_HALF);

endmodule

// File: rtl/shift_seq_ctrl.sv
// Full-duplex serial master that drives an external universal shift register:
// load the TX word, shift it out LSB first while shifting sdi into the MSB, then present q.
// Handshake: a request is accepted on the rising edge of c where tx_valid && tx_ready;
// rx_valid rises after the last shift and stays high until the next accept.
module shift_seq_ctrl
  import shift_seq_pkg::*;
#(
  parameter int N   = 8,
  parameter int DIV = 4,
  localparam int BW = (N > 1) ? $clog2(N) : 1
) (
  input  logic         c,
  input  logic         rst,
  input  logic         tx_valid,
  output logic         tx_ready,
  input  logic [N-1:0] tx_data,
  output logic         rx_valid,
  output logic [N-1:0] rx_data,
  output logic         busy,
  output logic         sclk,
  output logic         cs_n,
  output logic         sdo,
  input  logic         sdi,
  output logic         reg_l,
  output logic         reg_r,
  output logic         reg_i,
  output logic [N-1:0] reg_d,
  input  logic [N-1:0] reg_q,
  output state_t       dbg_state
);

  localparam logic [BW-1:0] C_BIT_LAST = BW'(N - 1);

  state_t        r_state;
  logic [BW-1:0] r_bit_cnt;
  logic          r_rx_valid;
  logic          r_sdi_q;

  logic       w_accept;
  logic       w_in_shift;
  logic       w_sample;
  logic       w_shift;
  logic       w_sclk;
  logic [1:0] w_mode;

  assign w_accept   = (r_state == IDLE) && tx_valid;
  assign w_in_shift = (r_state == SHIFT);

  shift_seq_timer #(.DIV(DIV)) u_timer (
    .c        (c),
    .rst      (rst),
    .i_start  (w_accept),
    .i_en     (w_in_shift),
    .o_sample (w_sample),
    .o_shift  (w_shift),
    .o_sclk   (w_sclk)
  );

  always_ff @(posedge c or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_bit_cnt  <= '0;
      r_rx_valid <= 1'b0;
      r_sdi_q    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (tx_valid) begin
            r_state    <= SHIFT;
            r_bit_cnt  <= '0;
            r_rx_valid <= 1'b0;
          end
        end
        SHIFT: begin
          if (w_sample) r_sdi_q <= sdi;
          if (w_shift) begin
            if (r_bit_cnt == C_BIT_LAST) begin
              r_state    <= DONE;
              r_rx_valid <= 1'b1;
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Load on the accept edge itself so the first bit is on q[0] as SHIFT begins.
  always_comb begin
    w_mode = MODE_HOLD;
    if (w_accept)     w_mode = MODE_LOAD;
    else if (w_shift) w_mode = MODE_SHR;
  end

  assign {reg_l, reg_r} = w_mode;
  assign reg_i     = w_shift ? r_sdi_q : 1'b0;
  assign reg_d     = tx_data;
  assign tx_ready  = (r_state == IDLE);
  assign busy      = (r_state != IDLE);
  assign cs_n      = !w_in_shift;
  assign sclk      = w_sclk;
  assign sdo       = w_in_shift && reg_q[0];
  assign rx_valid  = r_rx_valid;
  assign rx_data   = reg_q;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Bench for shift_seq_ctrl: universal shift registers beside each DUT, an SPI slave
// model, and a scoreboard comparing each received word and its serial framing.
module tb_shift_seq_ctrl;
  import shift_seq_pkg::*;

  localparam int N    = 8;
  localparam int DIV  = 4;
  localparam int DIV2 = 2;

  // ---------------- clock / reset ----------------
  logic c = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  always #5 c = ~c;
  always @(posedge c) cyc <= cyc + 1;

  // ---------------- DUT (DIV=4) ----------------
  logic         tx_valid = 1'b0, tx_ready, rx_valid, busy, sclk, cs_n, sdo, sdi;
  logic         reg_l, reg_r, reg_i;
  logic [N-1:0] tx_data = '0, rx_data, reg_d;
  logic [N-1:0] reg_q = '0;
  state_t       dbg_state;

  shift_seq_ctrl #(.N(N), .DIV(DIV)) u_dut (
    .c(c), .rst(rst), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .rx_valid(rx_valid), .rx_data(rx_data), .busy(busy), .sclk(sclk), .cs_n(cs_n),
    .sdo(sdo), .sdi(sdi), .reg_l(reg_l), .reg_r(reg_r), .reg_i(reg_i), .reg_d(reg_d),
    .reg_q(reg_q), .dbg_state(dbg_state)
  );

  always @(posedge c) begin
    case ({reg_l, reg_r})
      2'b11:   reg_q <= reg_d;
      2'b10:   reg_q <= {reg_i, reg_q[N-1:1]};
      2'b01:   reg_q <= {reg_q[N-2:0], reg_i};
      default: reg_q <= reg_q;
    endcase
  end

  // ---------------- DUT (DIV=2), loopback ----------------
  logic         tx_valid2 = 1'b0, tx_ready2, rx_valid2, busy2, sclk2, cs_n2, sdo2;
  logic         reg_l2, reg_r2, reg_i2;
  logic [N-1:0] tx_data2 = '0, rx_data2, reg_d2;
  logic [N-1:0] reg_q2 = '0;
  state_t       dbg_state2;

  shift_seq_ctrl #(.N(N), .DIV(DIV2)) u_dut2 (
    .c(c), .rst(rst), .tx_valid(tx_valid2), .tx_ready(tx_ready2), .tx_data(tx_data2),
    .rx_valid(rx_valid2), .rx_data(rx_data2), .busy(busy2), .sclk(sclk2), .cs_n(cs_n2),
    .sdo(sdo2), .sdi(sdo2), .reg_l(reg_l2), .reg_r(reg_r2), .reg_i(reg_i2), .reg_d(reg_d2),
    .reg_q(reg_q2), .dbg_state(dbg_state2)
  );

  always @(posedge c) begin
    case ({reg_l2, reg_r2})
      2'b11:   reg_q2 <= reg_d2;
      2'b10:   reg_q2 <= {reg_i2, reg_q2[N-1:1]};
      2'b01:   reg_q2 <= {reg_q2[N-2:0], reg_i2};
      default: reg_q2 <= reg_q2;
    endcase
  end

  // ---------------- SPI slave model ----------------
  bit           loop_mode = 1'b1;
  logic [N-1:0] slave_word = '0;
  logic [N-1:0] mosi_word = '0;
  int           sl_idx = 0;

  always_comb sdi = loop_mode ? sdo : ((sl_idx < N) ? slave_word[sl_idx] : 1'b0);

  always @(negedge cs_n) begin
    sl_idx    = 0;
    mosi_word = '0;
  end

  always @(posedge sclk) begin
    if (sl_idx < N) mosi_word[sl_idx] = sdo;
    sl_idx++;
  end

  // ---------------- scoreboard ----------------
  logic [N-1:0] exp_q[$];
  logic [N-1:0] exp_mosi_q[$];
  int           acc_q[$];
  int           checks = 0;
  int           errors = 0;
  int           last_acc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  int   mon_hi = 0, mon_pulses = 0, mon_cslow = 0;
  logic sclk_prev = 1'b0, rxv_prev = 1'b0;

  always @(negedge c) begin
    if (rst) begin
      mon_hi = 0; mon_pulses = 0; mon_cslow = 0;
      sclk_prev = 1'b0; rxv_prev = 1'b0;
    end else begin
      mon_hi += int'(sclk);
      if (sclk && !sclk_prev) mon_pulses++;
      mon_cslow += int'(!cs_n);
      sclk_prev = sclk;
      if (rx_valid && !rxv_prev) begin
        if (exp_q.size() == 0) begin
          check("unexpected_rx_valid", 1, 0);
        end else begin
          check("rx_data", rx_data, exp_q.pop_front());
          check("sdo_bits", mosi_word, exp_mosi_q.pop_front());
          check("rx_latency", cyc - acc_q.pop_front(), N * DIV);
          check("sclk_pulses", mon_pulses, N);
          check("sclk_high_cycles", mon_hi, N * DIV / 2);
          check("cs_n_low_cycles", mon_cslow, N * DIV);
        end
        mon_hi = 0; mon_pulses = 0; mon_cslow = 0;
      end
      rxv_prev = rx_valid;
    end
  end

  // ---------------- drivers ----------------
  task automatic send(input logic [N-1:0] w, input bit lb, input logic [N-1:0] sw,
                      input bit hold, input logic [N-1:0] next_data);
    int t = 0;
    @(negedge c);
    tx_valid = 1'b1;
    tx_data  = w;
    while (!tx_ready && t < 200) begin
      @(negedge c);
      t++;
    end
    if (!tx_ready) begin
      check("accept_timeout", 0, 1);
      tx_valid = 1'b0;
      return;
    end
    loop_mode  = lb;
    slave_word = sw;
    exp_q.push_back(lb ? w : sw);
    exp_mosi_q.push_back(w);
    @(posedge c);
    #1;
    acc_q.push_back(cyc);
    last_acc = cyc;
    if (hold) tx_data = next_data;
    else      tx_valid = 1'b0;
  endtask

  task automatic run2(input logic [N-1:0] w);
    int t = 0, a, hi = 0, pulses = 0;
    logic prev = 1'b0;
    @(negedge c);
    while (!tx_ready2 && t < 100) begin @(negedge c); t++; end
    tx_valid2 = 1'b1;
    tx_data2  = w;
    @(posedge c);
    #1;
    a = cyc;
    tx_valid2 = 1'b0;
    t = 0;
    while (!rx_valid2 && t < 100) begin
      @(negedge c);
      hi += int'(sclk2);
      if (sclk2 && !prev) pulses++;
      prev = sclk2;
      t++;
    end
    check("div2_rx_valid", rx_valid2, 1);
    check("div2_rx_data", rx_data2, w);
    check("div2_latency", cyc - a, N * DIV2);
    check("div2_sclk_pulses", pulses, N);
    check("div2_sclk_high", hi, N * DIV2 / 2);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_tx_ready"}, tx_ready, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_sclk"}, sclk, 0);
    check({tag, "_cs_n"}, cs_n, 1);
    check({tag, "_sdo"}, sdo, 0);
    check({tag, "_reg_lr"}, {reg_l, reg_r}, 2'b00);
    check({tag, "_reg_i"}, reg_i, 0);
    check({tag, "_rx_valid"}, rx_valid, 0);
    check({tag, "_state"}, dbg_state, IDLE);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [N-1:0] w;
    int t;
    int prev_acc;

    repeat (3) @(negedge c);
    check_idle_outputs("reset");
    rst = 1'b0;
    @(negedge c);
    check("div2_reset_ready", tx_ready2, 1);

    // loopback 0xA5, then sdi held high sending 0x00
    send(8'hA5, 1'b1, '0, 1'b0, '0);
    #2;
    check("shift_state", dbg_state, SHIFT);
    check("shift_cs_n", cs_n, 0);
    send(8'h00, 1'b0, 8'hFF, 1'b0, '0);

    // request held high through a busy transfer: only accepted after DONE
    send(8'h81, 1'b1, '0, 1'b1, 8'h3C);
    prev_acc = last_acc;
    send(8'h3C, 1'b1, '0, 1'b0, '0);
    check("held_request_gap", last_acc - prev_acc, N * DIV + 2);

    // randomized transfers, loopback or slave-driven sdi
    for (int i = 0; i < 24; i++) begin
      w = N'($urandom);
      send(w, 1'($urandom_range(0, 1)), N'($urandom), 1'b0, '0);
      repeat ($urandom_range(0, 3)) @(negedge c);
    end

    // abandon a transfer with an asynchronous reset during bit 3
    send(N'($urandom), 1'b1, '0, 1'b0, '0);
    t = 0;
    while (sl_idx < 4 && t < 200) begin @(posedge c); t++; end
    check("reach_bit3", (sl_idx >= 4), 1);
    @(posedge c);
    #3;
    void'(exp_q.pop_back());
    void'(exp_mosi_q.pop_back());
    void'(acc_q.pop_back());
    rst = 1'b1;
    #1;
    check_idle_outputs("abort");
    @(negedge c);
    @(negedge c);
    rst = 1'b0;
    @(negedge c);
    check("abort_ready_after", tx_ready, 1);
    check("abort_rx_valid_after", rx_valid, 0);

    send(8'h96, 1'b1, '0, 1'b0, '0);
    send(N'($urandom), 1'b0, N'($urandom), 1'b0, '0);

    t = 0;
    while (exp_q.size() != 0 && t < 500) begin @(negedge c); t++; end
    check("scoreboard_drained", exp_q.size(), 0);

    // DIV=2 instance, loopback
    run2(8'h5A);
    for (int i = 0; i < 4; i++) run2(N'($urandom));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
